// File: rtl/priority_encoder_pkg.sv
// priority_encoder_pkg
// Types and helpers used by the priority_encoder_rr block:
//   state_t  - grant FSM state encoding (IDLE, GRANT)
//   wrap_inc - increment modulo an arbitrary width, used for the round-robin
//              pointer. The width does not have to be a power of two.
package priority_encoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int unsigned wrap_inc(input int unsigned val,
                                             input int unsigned width);
        return (val + 1 >= width) ? 0 : val + 1;
    endfunction

endpackage

// File: rtl/priority_encoder_rr_search.sv
// priority_encoder_rr_search
// Combinational find-first-set with a wrap-around scan. The scan visits
// index start, start+1, ..., WIDTH-1, 0, ..., start-1 and reports the first
// set bit it finds.
// Ports:
//   req   [WIDTH-1:0] in  - request vector
//   start [OUT_W-1:0] in  - first index to examine (must be < WIDTH)
//   idx   [OUT_W-1:0] out - index of the first set bit found (0 if none)
//   found             out - at least one bit of req is set
module priority_encoder_rr_search
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [OUT_W-1:0] start,
    output logic [OUT_W-1:0] idx,
    output logic             found
);

    // Two ascending passes: the first covers [start, WIDTH-1], the second
    // wraps around to cover [0, start-1]. The first hit of either pass wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && req[i] && (i >= int'(start))) begin
                found = 1'b1;
                idx   = OUT_W'(i);
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (!found && req[i] && (i < int'(start))) begin
                found = 1'b1;
                idx   = OUT_W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr
// Registered N-input priority encoder with a valid/ack grant handshake and a
// selectable fixed-priority (highest index wins) or round-robin mode.
// Optional feature macro: PRIORITY_ENCODER_RR_ONEHOT_EN adds a registered
// one-hot grant output.
// Ports:
//   clk                 in  - clock, rising edge
//   rst                 in  - asynchronous active-high reset
//   enable              in  - 0 blocks new grants and aborts a held grant
//   mode                in  - 0 fixed priority, 1 round-robin
//   in    [WIDTH-1:0]   in  - request lines
//   ack                 in  - consumer accepts out (only while valid)
//   out   [OUT_W-1:0]   out - encoded index of the granted request
//   valid               out - out holds a live grant
//   grant [WIDTH-1:0]   out - one-hot of out while valid (macro only)
//
// state | meaning
// IDLE  | no grant held; sample mode/in and latch a winner when enabled
// GRANT | out held stable with valid=1 until ack or enable drop
module priority_encoder_rr
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] in,
    input  logic             ack,
    output logic [OUT_W-1:0] out,
    output logic             valid
`ifdef PRIORITY_ENCODER_RR_ONEHOT_EN
    ,
    output logic [WIDTH-1:0] grant
`endif
);

    localparam logic [OUT_W-1:0] LAST_IDX = OUT_W'(WIDTH - 1);

    state_t           state;
    logic [OUT_W-1:0] ptr;
    logic             mode_q;

    logic [WIDTH-1:0] req_rev;
    logic [WIDTH-1:0] req_sel;
    logic [OUT_W-1:0] start_sel;
    logic [OUT_W-1:0] search_idx;
    logic             search_found;
    logic [OUT_W-1:0] winner;

    // Fixed priority is a find-first from 0 on the bit-reversed vector; the
    // resulting index is mirrored back to recover the highest set bit.
    always_comb begin
        req_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            req_rev[i] = in[WIDTH-1-i];
        end
        req_sel   = mode ? in : req_rev;
        start_sel = mode ? ptr : '0;
        winner    = mode ? search_idx : (LAST_IDX - search_idx);
    end

    priority_encoder_rr_search #(
        .WIDTH (WIDTH)
    ) u_search (
        .req   (req_sel),
        .start (start_sel),
        .idx   (search_idx),
        .found (search_found)
    );

    // mode_q remembers which mode produced the held grant, since mode is
    // only sampled in IDLE but decides whether ack advances ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            out    <= '0;
            valid  <= 1'b0;
            ptr    <= '0;
            mode_q <= 1'b0;
`ifdef PRIORITY_ENCODER_RR_ONEHOT_EN
            grant  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable && search_found) begin
                        state  <= GRANT;
                        out    <= winner;
                        valid  <= 1'b1;
                        mode_q <= mode;
`ifdef PRIORITY_ENCODER_RR_ONEHOT_EN
                        grant  <= WIDTH'(1) << winner;
`endif
                    end
                end
                GRANT: begin
                    // enable low takes precedence: an ack in the same cycle
                    // is treated as an abort and leaves ptr alone.
                    if (!enable || ack) begin
                        state <= IDLE;
                        valid <= 1'b0;
`ifdef PRIORITY_ENCODER_RR_ONEHOT_EN
                        grant <= '0;
`endif
                        if (enable && mode_q) begin
                            ptr <= OUT_W'(wrap_inc(32'(out), WIDTH));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
